ct_clint_apb_bridge: RTL and testbench



---
 rtl/ct_clint_pkg.sv | 27 ++
 rtl/ct_clint_apb_timeout.sv | 40 ++++
 rtl/ct_clint_apb_bridge.sv | 154 +++++++++++++++
 tb/tb_ct_clint_apb_bridge.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/ct_clint_pkg.sv
// Shared definitions for the CLINT APB bridge: FSM encoding, privilege codes and
// CLINT register offsets.
package ct_clint_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StSetup  = 2'b01,
    StAccess = 2'b10,
    StResp   = 2'b11
  } apb_state_e;

  localparam logic [1:0] PROT_USER = 2'b00;
  localparam logic [1:0] PROT_SUPV = 2'b01;
  localparam logic [1:0] PROT_MACH = 2'b11;

  localparam logic [15:0] MSIP0     = 16'h0000;
  localparam logic [15:0] MTIMECMP0 = 16'h4000;
  localparam logic [15:0] MTIME     = 16'hBFF8;
  localparam logic [15:0] SSIP0     = 16'hC000;
  localparam logic [15:0] STIMECMP0 = 16'hD000;

  // Only word accesses are legal on the CLINT.
  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return addr_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/ct_clint_apb_timeout.sv
// ACCESS-phase watchdog for the CLINT APB bridge. Built only with CLINT_APB_TIMEOUT_EN.
module ct_clint_apb_timeout #(
  parameter int unsigned TO_CYC = 255
) (
  input  logic clint_clk,
  input  logic cpurst_b,
  input  logic arm_i,     // bridge is in SETUP, ACCESS starts next cycle
  input  logic access_i,  // bridge is in ACCESS
  input  logic pready_i,
  output logic expire_o
);

  localparam int unsigned CntW = $clog2(TO_CYC + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TO_CYC - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Expire on the TO_CYC-th ACCESS cycle that still has no pready.
  assign expire_o = access_i && !pready_i && (cnt_q == CntLast);

  // Clear on ACCESS entry, count stalled ACCESS cycles.
  always_comb begin
    cnt_d = cnt_q;
    if (arm_i) begin
      cnt_d = '0;
    end else if (access_i && !pready_i && !expire_o) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clint_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ct_clint_apb_bridge.sv
// Single-outstanding request to APB3 master bridge in front of the CLINT.
// Optional ACCESS timeout is enabled by defining CLINT_APB_TIMEOUT_EN.
module ct_clint_apb_bridge
  import ct_clint_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned TO_CYC = 255
) (
  input  logic              clint_clk,
  input  logic              cpurst_b,
  input  logic              req_vld,
  output logic              req_rdy,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_write,
  input  logic [31:0]       req_wdata,
  input  logic [1:0]        req_prot,
  output logic              rsp_vld,
  input  logic              rsp_rdy,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              psel_clint,
  output logic              penable,
  output logic [ADDR_W-1:0] paddr,
  output logic              pwrite,
  output logic [31:0]       pwdata,
  output logic [1:0]        pprot,
  input  logic              pready_clint,
  input  logic              perr_clint,
  input  logic [31:0]       prdata_clint
);

  apb_state_e        state_q, state_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic              pwrite_q, pwrite_d;
  logic [31:0]       pwdata_q, pwdata_d;
  logic [1:0]        pprot_q, pprot_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              timeout_hit;

`ifdef CLINT_APB_TIMEOUT_EN
  ct_clint_apb_timeout #(
    .TO_CYC (TO_CYC)
  ) u_timeout (
    .clint_clk (clint_clk),
    .cpurst_b  (cpurst_b),
    .arm_i     (state_q == StSetup),
    .access_i  (state_q == StAccess),
    .pready_i  (pready_clint),
    .expire_o  (timeout_hit)
  );
`else
  logic [31:0] unused_to_cyc;
  assign unused_to_cyc = TO_CYC;
  assign timeout_hit   = 1'b0;
`endif

  assign req_rdy    = (state_q == StIdle);
  assign rsp_vld    = (state_q == StResp);
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_err    = rsp_err_q;
  assign psel_clint = psel_q;
  assign penable    = penable_q;
  assign paddr      = paddr_q;
  assign pwrite     = pwrite_q;
  assign pwdata     = pwdata_q;
  assign pprot      = pprot_q;

  // Next-state and registered APB/response outputs.
  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    pprot_d     = pprot_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    unique case (state_q)
      StIdle: begin
        if (req_vld) begin
          paddr_d  = req_addr;
          pwrite_d = req_write;
          pwdata_d = req_wdata;
          pprot_d  = req_prot;
          if (is_misaligned(req_addr[1:0])) begin
            // Screened locally: answer with an error, never touch APB.
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
            state_d     = StResp;
          end else begin
            psel_d  = 1'b1;
            state_d = StSetup;
          end
        end
      end
      StSetup: begin
        penable_d = 1'b1;
        state_d   = StAccess;
      end
      StAccess: begin
        if (pready_clint) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_err_d   = perr_clint;
          // Slave read data is not trusted on writes or errors.
          rsp_rdata_d = (pwrite_q || perr_clint) ? 32'h0 : prdata_clint;
          state_d     = StResp;
        end else if (timeout_hit) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          state_d     = StResp;
        end
      end
      StResp: begin
        if (rsp_rdy) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clint_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q     <= StIdle;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      pprot_q     <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      pprot_q     <= pprot_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_ct_clint_apb_bridge.sv
// Directed bench for ct_clint_apb_bridge; the timeout case runs only with
// CLINT_APB_TIMEOUT_EN defined.
module tb_ct_clint_apb_bridge;
  import ct_clint_pkg::*;

  logic        clint_clk = 1'b0;
  logic        cpurst_b  = 1'b0;
  logic        req_vld   = 1'b0;
  logic        req_rdy;
  logic [31:0] req_addr  = '0;
  logic        req_write = 1'b0;
  logic [31:0] req_wdata = '0;
  logic [1:0]  req_prot  = '0;
  logic        rsp_vld;
  logic        rsp_rdy   = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        psel_clint;
  logic        penable;
  logic [31:0] paddr;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [1:0]  pprot;
  logic        pready_clint = 1'b0;
  logic        perr_clint   = 1'b0;
  logic [31:0] prdata_clint = '0;

  int n_chk  = 0;
  int n_pass = 0;

  ct_clint_apb_bridge #(
    .ADDR_W (32),
    .TO_CYC (4)
  ) dut (
    .clint_clk    (clint_clk),
    .cpurst_b     (cpurst_b),
    .req_vld      (req_vld),
    .req_rdy      (req_rdy),
    .req_addr     (req_addr),
    .req_write    (req_write),
    .req_wdata    (req_wdata),
    .req_prot     (req_prot),
    .rsp_vld      (rsp_vld),
    .rsp_rdy      (rsp_rdy),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .psel_clint   (psel_clint),
    .penable      (penable),
    .paddr        (paddr),
    .pwrite       (pwrite),
    .pwdata       (pwdata),
    .pprot        (pprot),
    .pready_clint (pready_clint),
    .perr_clint   (perr_clint),
    .prdata_clint (prdata_clint)
  );

  always #5 clint_clk = ~clint_clk;

  task automatic tick();
    @(posedge clint_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h, want %h", tag, obs, exp);
  endtask

  // Present one request for exactly one (accepting) cycle.
  task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] d,
                       input logic [1:0] p);
    req_vld   = 1'b1;
    req_addr  = a;
    req_write = w;
    req_wdata = d;
    req_prot  = p;
    tick();
    req_vld   = 1'b0;
  endtask

  initial begin
    // Reset values
    #3;
    chk("rst_req_rdy", {31'b0, req_rdy}, 32'd1);
    chk("rst_rsp_vld", {31'b0, rsp_vld}, 32'd0);
    chk("rst_psel", {31'b0, psel_clint}, 32'd0);
    chk("rst_penable", {31'b0, penable}, 32'd0);
    chk("rst_paddr", paddr, 32'h0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    #10 cpurst_b = 1'b1;
    tick();

    // Machine write 1 to MTIMECMP0, pready in the second ACCESS cycle
    issue({16'h0, MTIMECMP0}, 1'b1, 32'h0000_0001, PROT_MACH);
    chk("wr_setup_psel", {30'b0, psel_clint, penable}, 32'b10);
    chk("wr_setup_paddr", paddr, 32'h0000_4000);
    chk("wr_setup_ctl", {28'b0, req_rdy, pwrite, pprot}, 32'b0111);
    chk("wr_pwdata", pwdata, 32'h1);
    tick();
    chk("wr_acc1", {30'b0, psel_clint, penable}, 32'b11);
    tick();
    chk("wr_acc2", {29'b0, psel_clint, penable, rsp_vld}, 32'b110);
    pready_clint = 1'b1;
    prdata_clint = 32'hDEAD_BEEF;
    tick();
    pready_clint = 1'b0;
    chk("wr_rsp", {29'b0, rsp_vld, rsp_err, psel_clint | penable}, 32'b100);
    chk("wr_rdata", rsp_rdata, 32'h0);
    rsp_rdy = 1'b1;
    tick();
    rsp_rdy = 1'b0;
    chk("wr_done", {30'b0, req_rdy, rsp_vld}, 32'b10);
    chk("idle_paddr_hold", paddr, 32'h0000_4000);

    // Machine read 0xD004 returning all ones
    issue(32'h0000_D004, 1'b0, 32'h0, PROT_MACH);
    chk("rd_setup_paddr", paddr, 32'h0000_D004);
    tick();
    chk("rd_acc_paddr", paddr, 32'h0000_D004);
    tick();
    chk("rd_acc2_paddr", paddr, 32'h0000_D004);
    pready_clint = 1'b1;
    prdata_clint = 32'hFFFF_FFFF;
    tick();
    pready_clint = 1'b0;
    chk("rd_rsp", {30'b0, rsp_vld, rsp_err}, 32'b10);
    chk("rd_rdata", rsp_rdata, 32'hFFFF_FFFF);
    rsp_rdy = 1'b1;
    tick();
    rsp_rdy = 1'b0;

    // User read of MSIP0 with slave error and undefined data
    issue({16'h0, MSIP0}, 1'b0, 32'h0, PROT_USER);
    chk("err_pprot", {30'b0, pprot}, 32'b00);
    tick();
    tick();
    pready_clint = 1'b1;
    perr_clint   = 1'b1;
    prdata_clint = 32'hxxxx_xxxx;
    tick();
    pready_clint = 1'b0;
    perr_clint   = 1'b0;
    prdata_clint = 32'h0;
    chk("err_rsp", {30'b0, rsp_vld, rsp_err}, 32'b11);
    chk("err_rdata", rsp_rdata, 32'h0);
    rsp_rdy = 1'b1;
    tick();
    rsp_rdy = 1'b0;

    // Misaligned 0x4002: error at accept+1, no APB select
    issue(32'h0000_4002, 1'b0, 32'h0, PROT_MACH);
    chk("mis_rsp", {28'b0, rsp_vld, rsp_err, psel_clint, req_rdy}, 32'b1100);
    chk("mis_rdata", rsp_rdata, 32'h0);
    tick();
    chk("mis_hold", {28'b0, rsp_vld, rsp_err, psel_clint, req_rdy}, 32'b1100);
    tick();
    chk("mis_hold2", {30'b0, psel_clint, req_rdy}, 32'b00);
    rsp_rdy = 1'b1;
    tick();
    rsp_rdy = 1'b0;
    chk("mis_done", {30'b0, req_rdy, rsp_vld}, 32'b10);

    // Response back-pressure with a second request pending
    issue({16'h0, SSIP0}, 1'b0, 32'h0, PROT_SUPV);
    tick();
    tick();
    pready_clint = 1'b1;
    prdata_clint = 32'h1234_5678;
    tick();
    pready_clint = 1'b0;
    prdata_clint = 32'h0;
    req_vld   = 1'b1;
    req_addr  = {16'h0, STIMECMP0};
    req_write = 1'b1;
    req_wdata = 32'hA5A5_0000;
    req_prot  = PROT_SUPV;
    for (int i = 0; i < 5; i++) begin
      chk("bp_ctl", {29'b0, rsp_vld, req_rdy, psel_clint}, 32'b100);
      chk("bp_rdata", rsp_rdata, 32'h1234_5678);
      tick();
    end
    rsp_rdy = 1'b1;
    tick();
    rsp_rdy = 1'b0;
    chk("bp_idle", {29'b0, req_rdy, rsp_vld, psel_clint}, 32'b100);
    tick();
    req_vld = 1'b0;
    chk("bp_second_acc", {30'b0, psel_clint, req_rdy}, 32'b10);
    chk("bp_second_addr", paddr, 32'h0000_D000);
    chk("bp_second_data", pwdata, 32'hA5A5_0000);
    tick();
    tick();
    pready_clint = 1'b1;
    tick();
    pready_clint = 1'b0;
    rsp_rdy = 1'b1;
    tick();
    rsp_rdy = 1'b0;

    // Reset pulse during ACCESS drops the transfer
    issue({16'h0, MTIMECMP0}, 1'b0, 32'h0, PROT_MACH);
    tick();
    chk("rst_mid_acc", {30'b0, psel_clint, penable}, 32'b11);
    #2 cpurst_b = 1'b0;
    #1;
    chk("rst_mid_async", {29'b0, psel_clint, penable, rsp_vld}, 32'b000);
    #3 cpurst_b = 1'b1;
    tick();
    chk("rst_mid_after", {29'b0, req_rdy, psel_clint, rsp_vld}, 32'b100);
    chk("rst_mid_paddr", paddr, 32'h0);

`ifdef CLINT_APB_TIMEOUT_EN
    // Timeout with TO_CYC=4: four stalled ACCESS cycles then error
    issue({16'h0, MTIMECMP0}, 1'b0, 32'h0, PROT_MACH);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("to_access", {29'b0, psel_clint, penable, rsp_vld}, 32'b110);
    end
    tick();
    chk("to_rsp", {28'b0, rsp_vld, rsp_err, psel_clint, penable}, 32'b1100);
    chk("to_rdata", rsp_rdata, 32'h0);
    rsp_rdy = 1'b1;
    tick();
    rsp_rdy = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
